// File: rtl/array_allocator_if.sv
// Request/response bundle between execution units and the array handle allocator.
interface array_allocator_if #(
    parameter int MemoryElementWidth = 12,
    parameter int NRequesters        = 2
);
    logic [NRequesters-1:0]                    reqAlloc;
    logic [NRequesters-1:0]                    reqFree;
    logic [NRequesters*MemoryElementWidth-1:0] freeHandle;
    logic [NRequesters-1:0]                    grant;
    logic [MemoryElementWidth-1:0]             resultHandle;
    logic                                      resultError;
    logic                                      sizeClear;
    logic [MemoryElementWidth-1:0]             sizeClearIndex;
    logic [MemoryElementWidth-1:0]             allocs;
    logic [MemoryElementWidth-1:0]             inUse;
    logic                                      busy;

    modport master (
        output reqAlloc, reqFree, freeHandle,
        input  grant, resultHandle, resultError, sizeClear, sizeClearIndex,
               allocs, inUse, busy
    );

    modport slave (
        input  reqAlloc, reqFree, freeHandle,
        output grant, resultHandle, resultError, sizeClear, sizeClearIndex,
               allocs, inUse, busy
    );
endinterface

// File: rtl/array_allocator.sv
// Round-robin allocator of array handles: LIFO reuse of freed handles, else fresh from a high-water count.
// Latency: request sampled in IDLE at edge N, sizeClear during N+1, one-hot grant during N+2.
// Backpressure: level requests are held by the unit until granted; new requests wait for IDLE.
module array_allocator #(
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 4,
    parameter int NRequesters        = 2
) (
    input logic              clock,
    input logic              reset,
    array_allocator_if.slave bus
);
    localparam int MW = MemoryElementWidth;
    localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int RW = (NRequesters > 1) ? $clog2(NRequesters) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state;
    logic [MW-1:0]          stack [NArrays];
    logic [MW-1:0]          freed_top;
    logic [MW-1:0]          alloc_cnt;
    logic [MW-1:0]          use_cnt;
    logic [NArrays-1:0]     bitmap;
    logic [RW-1:0]          rr;
    logic [RW-1:0]          winner;
    logic                   op_alloc;
    logic                   op_free;
    logic [MW-1:0]          hdl;

    logic [NRequesters-1:0] grant_q;
    logic [MW-1:0]          res_hdl;
    logic                   res_err;
    logic                   sc_q;
    logic [MW-1:0]          sci_q;
    logic                   busy_q;

    logic [NRequesters-1:0] pending;
    logic [MW-1:0]          fh [NRequesters];
    logic [RW-1:0]          pick;
    logic [RW-1:0]          cand;
    logic                   c_alloc;
    logic                   c_free;
    logic [MW-1:0]          c_hdl;
    logic [MW-1:0]          top_m1;
    logic [MW-1:0]          new_hdl;
    logic                   alloc_ok;
    logic                   free_ok;

    assign pending = bus.reqAlloc | bus.reqFree;

    always_comb begin
        for (int r = 0; r < NRequesters; r++) begin
            fh[r] = bus.freeHandle[r*MW +: MW];
        end
    end

    // Walk downwards so the last hit is the first pending requester at or after rr.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int i = NRequesters - 1; i >= 0; i--) begin
            cand = RW'((int'(rr) + i) % NRequesters);
            if (pending[cand]) begin
                pick = cand;
            end
        end
    end

    // The outcome is evaluated in IDLE (to register sizeClear early) and again in EXEC
    // on the latched request; nothing it depends on changes in between.
    always_comb begin
        if (state == IDLE) begin
            c_alloc = bus.reqAlloc[pick];
            c_free  = bus.reqFree[pick];
            c_hdl   = fh[pick];
        end else begin
            c_alloc = op_alloc;
            c_free  = op_free;
            c_hdl   = hdl;
        end
        top_m1   = freed_top - MW'(1);
        new_hdl  = (freed_top != '0) ? stack[top_m1[AW-1:0]] : alloc_cnt;
        alloc_ok = c_alloc && !c_free && ((freed_top != '0) || (alloc_cnt < MW'(NArrays)));
        free_ok  = c_free && !c_alloc && (c_hdl < alloc_cnt) && bitmap[c_hdl[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            freed_top <= '0;
            alloc_cnt <= '0;
            use_cnt   <= '0;
            bitmap    <= '0;
            rr        <= '0;
            winner    <= '0;
            op_alloc  <= 1'b0;
            op_free   <= 1'b0;
            hdl       <= '0;
            grant_q   <= '0;
            res_hdl   <= '0;
            res_err   <= 1'b0;
            sc_q      <= 1'b0;
            sci_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        winner   <= pick;
                        op_alloc <= c_alloc;
                        op_free  <= c_free;
                        hdl      <= c_hdl;
                        sc_q     <= alloc_ok;
                        if (alloc_ok) begin
                            sci_q <= new_hdl;
                        end
                        busy_q   <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    sc_q <= 1'b0;
                    if (alloc_ok) begin
                        if (freed_top != '0) begin
                            freed_top <= top_m1;
                        end else begin
                            alloc_cnt <= alloc_cnt + MW'(1);
                        end
                        bitmap[new_hdl[AW-1:0]] <= 1'b1;
                        use_cnt <= use_cnt + MW'(1);
                    end else if (free_ok) begin
                        stack[freed_top[AW-1:0]] <= c_hdl;
                        freed_top <= freed_top + MW'(1);
                        bitmap[c_hdl[AW-1:0]] <= 1'b0;
                        use_cnt <= use_cnt - MW'(1);
                    end
                    grant_q <= NRequesters'(1) << winner;
                    res_hdl <= alloc_ok ? new_hdl : '0;
                    res_err <= !(alloc_ok || free_ok);
                    state   <= RESP;
                end
                RESP: begin
                    grant_q <= '0;
                    res_hdl <= '0;
                    res_err <= 1'b0;
                    rr      <= (int'(winner) == NRequesters - 1) ? '0 : winner + RW'(1);
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant          = grant_q;
    assign bus.resultHandle   = res_hdl;
    assign bus.resultError    = res_err;
    assign bus.sizeClear      = sc_q;
    assign bus.sizeClearIndex = sci_q;
    assign bus.allocs         = alloc_cnt;
    assign bus.inUse          = use_cnt;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_array_allocator.sv
// Bench for array_allocator: directed scenarios plus random traffic against a queue-based model.
module tb_array_allocator;
    localparam int MW = 12;
    localparam int NA = 4;
    localparam int NR = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    array_allocator_if #(.MemoryElementWidth(MW), .NRequesters(NR)) bus ();

    array_allocator #(.MemoryElementWidth(MW), .NArrays(NA), .NRequesters(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: freed handles as a LIFO queue, high-water count, in-use flags.
    int m_freed[$];
    int m_allocs;
    bit m_used[NA];
    int m_inuse;

    task automatic model_reset();
        m_freed.delete();
        m_allocs = 0;
        m_inuse  = 0;
        foreach (m_used[i]) m_used[i] = 1'b0;
    endtask

    task automatic model_apply(input bit a, input bit f, input int h,
                               output bit e_err, output int e_hdl, output bit e_sc);
        e_err = 1'b0; e_hdl = 0; e_sc = 1'b0;
        if (a && f) begin
            e_err = 1'b1;
        end else if (a) begin
            if (m_freed.size() > 0) e_hdl = m_freed.pop_back();
            else if (m_allocs < NA) begin e_hdl = m_allocs; m_allocs++; end
            else e_err = 1'b1;
            if (!e_err) begin m_used[e_hdl] = 1'b1; m_inuse++; e_sc = 1'b1; end
        end else if (f) begin
            if (h >= m_allocs || !m_used[h]) e_err = 1'b1;
            else begin m_freed.push_back(h); m_used[h] = 1'b0; m_inuse--; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.reqAlloc = '0;
        bus.reqFree = '0;
        bus.freeHandle = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // One request from requester r, held until its grant or a 20-cycle bound.
    task automatic run_req(input int r, input bit a, input bit f, input logic [MW-1:0] h,
                           output bit got, output logic [NR-1:0] gv, output logic [MW-1:0] rh,
                           output logic re, output bit sc, output logic [MW-1:0] sci,
                           output int lat, output logic bz);
        got = 1'b0; gv = '0; rh = '0; re = 1'b0; sc = 1'b0; sci = '0; lat = 0; bz = 1'b0;
        @(negedge clock);
        bus.reqAlloc[r] = a;
        bus.reqFree[r] = f;
        bus.freeHandle[r*MW +: MW] = h;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) bz = bus.busy;
            if (bus.sizeClear === 1'b1) begin sc = 1'b1; sci = bus.sizeClearIndex; end
            if (bus.grant[r] === 1'b1) begin
                got = 1'b1; gv = bus.grant; rh = bus.resultHandle; re = bus.resultError; lat = c;
                break;
            end
        end
        bus.reqAlloc[r] = 1'b0;
        bus.reqFree[r] = 1'b0;
    endtask

    bit got, sc;
    logic [NR-1:0] gv;
    logic [MW-1:0] rh, sci;
    logic re, bz;
    int lat;

    task automatic test_reset();
        do_reset();
        checks++; if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant got=%0h want=0", bus.grant); end
        checks++; if (bus.resultHandle !== '0) begin errors++; $display("FAIL reset_handle got=%0d want=0", bus.resultHandle); end
        checks++; if (bus.resultError !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", bus.resultError); end
        checks++; if (bus.sizeClear !== 1'b0 || bus.sizeClearIndex !== '0) begin errors++; $display("FAIL reset_sizeclear got=%b/%0d want=0/0", bus.sizeClear, bus.sizeClearIndex); end
        checks++; if (bus.allocs !== '0 || bus.inUse !== '0) begin errors++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.allocs, bus.inUse); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_alloc_fill();
        for (int i = 0; i < NA; i++) begin
            run_req(0, 1'b1, 1'b0, '0, got, gv, rh, re, sc, sci, lat, bz);
            checks++; if (!got || lat != 2) begin errors++; $display("FAIL fill_latency[%0d] got=%0d want=2", i, lat); end
            checks++; if (gv !== 2'b01) begin errors++; $display("FAIL fill_grant[%0d] got=%b want=01", i, gv); end
            checks++; if (rh !== MW'(i) || re !== 1'b0) begin errors++; $display("FAIL fill_handle[%0d] got=%0d/%b want=%0d/0", i, rh, re, i); end
            checks++; if (!sc || sci !== MW'(i)) begin errors++; $display("FAIL fill_sizeclear[%0d] got=%b/%0d want=1/%0d", i, sc, sci, i); end
            checks++; if (bz !== 1'b1) begin errors++; $display("FAIL fill_busy[%0d] got=%b want=1", i, bz); end
        end
        checks++; if (bus.allocs !== MW'(4) || bus.inUse !== MW'(4)) begin errors++; $display("FAIL fill_counts got=%0d/%0d want=4/4", bus.allocs, bus.inUse); end
    endtask

    task automatic test_full();
        run_req(0, 1'b1, 1'b0, '0, got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || re !== 1'b1 || rh !== '0) begin errors++; $display("FAIL full_error got=%b/%b/%0d want=1/1/0", got, re, rh); end
        checks++; if (sc) begin errors++; $display("FAIL full_sizeclear got=1 want=0"); end
        checks++; if (bus.allocs !== MW'(4) || bus.inUse !== MW'(4)) begin errors++; $display("FAIL full_counts got=%0d/%0d want=4/4", bus.allocs, bus.inUse); end
    endtask

    task automatic test_lifo();
        run_req(0, 1'b0, 1'b1, MW'(1), got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || re !== 1'b0 || rh !== '0 || sc) begin errors++; $display("FAIL lifo_free1 got=%b/%b/%0d/%b want=1/0/0/0", got, re, rh, sc); end
        checks++; if (bus.inUse !== MW'(3)) begin errors++; $display("FAIL lifo_inuse1 got=%0d want=3", bus.inUse); end
        run_req(1, 1'b0, 1'b1, MW'(3), got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || re !== 1'b0 || gv !== 2'b10) begin errors++; $display("FAIL lifo_free3 got=%b/%b/%b want=1/0/10", got, re, gv); end
        checks++; if (bus.inUse !== MW'(2)) begin errors++; $display("FAIL lifo_inuse2 got=%0d want=2", bus.inUse); end
        run_req(0, 1'b1, 1'b0, '0, got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (rh !== MW'(3) || re !== 1'b0 || sci !== MW'(3)) begin errors++; $display("FAIL lifo_alloc_a got=%0d/%b/%0d want=3/0/3", rh, re, sci); end
        run_req(0, 1'b1, 1'b0, '0, got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (rh !== MW'(1) || re !== 1'b0 || sci !== MW'(1)) begin errors++; $display("FAIL lifo_alloc_b got=%0d/%b/%0d want=1/0/1", rh, re, sci); end
        checks++; if (bus.allocs !== MW'(4) || bus.inUse !== MW'(4)) begin errors++; $display("FAIL lifo_counts got=%0d/%0d want=4/4", bus.allocs, bus.inUse); end
    endtask

    task automatic test_double_free();
        run_req(0, 1'b0, 1'b1, MW'(2), got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || re !== 1'b0 || bus.inUse !== MW'(3)) begin errors++; $display("FAIL dfree_first got=%b/%b/%0d want=1/0/3", got, re, bus.inUse); end
        run_req(0, 1'b0, 1'b1, MW'(2), got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || re !== 1'b1 || bus.inUse !== MW'(3)) begin errors++; $display("FAIL dfree_second got=%b/%b/%0d want=1/1/3", got, re, bus.inUse); end
        run_req(1, 1'b0, 1'b1, MW'(7), got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || re !== 1'b1 || bus.inUse !== MW'(3)) begin errors++; $display("FAIL free_range got=%b/%b/%0d want=1/1/3", got, re, bus.inUse); end
    endtask

    task automatic test_illegal();
        run_req(1, 1'b1, 1'b1, '0, got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || gv !== 2'b10 || re !== 1'b1 || rh !== '0) begin errors++; $display("FAIL illegal_resp got=%b/%b/%b/%0d want=1/10/1/0", got, gv, re, rh); end
        checks++; if (sc || bus.allocs !== MW'(4) || bus.inUse !== MW'(3)) begin errors++; $display("FAIL illegal_state got=%b/%0d/%0d want=0/4/3", sc, bus.allocs, bus.inUse); end
        run_req(1, 1'b1, 1'b0, '0, got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (rh !== MW'(2) || re !== 1'b0) begin errors++; $display("FAIL illegal_after got=%0d/%b want=2/0", rh, re); end
    endtask

    task automatic test_round_robin();
        int k = 0;
        logic [NR-1:0] ev;
        do_reset();
        bus.reqAlloc = '1;
        for (int c = 1; c <= 40 && k < 4; c++) begin
            @(negedge clock);
            if (bus.grant !== '0) begin
                ev = NR'(1 << (k % NR));
                checks++; if (bus.grant !== ev) begin errors++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus.grant, ev); end
                checks++; if (c != 2 + 3 * k) begin errors++; $display("FAIL rr_cycle[%0d] got=%0d want=%0d", k, c, 2 + 3 * k); end
                checks++; if (bus.resultHandle !== MW'(k)) begin errors++; $display("FAIL rr_handle[%0d] got=%0d want=%0d", k, bus.resultHandle, k); end
                k++;
            end
        end
        bus.reqAlloc = '0;
        checks++; if (k != 4) begin errors++; $display("FAIL rr_count got=%0d want=4", k); end
    endtask

    task automatic test_reset_exec();
        int ng = 0;
        do_reset();
        @(negedge clock);
        bus.reqAlloc[0] = 1'b1;
        @(negedge clock);
        checks++; if (bus.sizeClear !== 1'b1) begin errors++; $display("FAIL rexec_inexec got=%b want=1", bus.sizeClear); end
        reset = 1'b1;
        bus.reqAlloc[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            if (bus.grant !== '0) ng++;
            @(negedge clock);
        end
        checks++; if (ng != 0) begin errors++; $display("FAIL rexec_grant got=%0d grants want=0", ng); end
        checks++; if (bus.allocs !== '0 || bus.inUse !== '0) begin errors++; $display("FAIL rexec_counts got=%0d/%0d want=0/0", bus.allocs, bus.inUse); end
        run_req(0, 1'b1, 1'b0, '0, got, gv, rh, re, sc, sci, lat, bz);
        checks++; if (!got || rh !== '0 || re !== 1'b0 || bus.allocs !== MW'(1)) begin errors++; $display("FAIL rexec_next got=%b/%0d/%b/%0d want=1/0/0/1", got, rh, re, bus.allocs); end
    endtask

    task automatic test_random();
        int r, op, h, e_hdl;
        bit a, f, e_err, e_sc;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, NR - 1);
            op = $urandom_range(0, 9);
            h  = $urandom_range(0, 5);
            a  = (op <= 4) || (op == 9);
            f  = (op >= 5);
            model_apply(a, f, h, e_err, e_hdl, e_sc);
            run_req(r, a, f, MW'(h), got, gv, rh, re, sc, sci, lat, bz);
            checks++; if (!got || lat != 2 || gv !== NR'(1 << r)) begin errors++; $display("FAIL rnd_grant[%0d] got=%b/%0d/%b want=1/2/%0d", n, got, lat, gv, r); end
            checks++; if (re !== e_err || rh !== MW'(e_hdl)) begin errors++; $display("FAIL rnd_result[%0d] got=%b/%0d want=%b/%0d", n, re, rh, e_err, e_hdl); end
            checks++; if (sc !== e_sc || (e_sc && sci !== MW'(e_hdl))) begin errors++; $display("FAIL rnd_sizeclear[%0d] got=%b/%0d want=%b/%0d", n, sc, sci, e_sc, e_hdl); end
            checks++; if (bus.allocs !== MW'(m_allocs) || bus.inUse !== MW'(m_inuse)) begin errors++; $display("FAIL rnd_counts[%0d] got=%0d/%0d want=%0d/%0d", n, bus.allocs, bus.inUse, m_allocs, m_inuse); end
        end
    endtask

    initial begin
        test_reset();
        test_alloc_fill();
        test_full();
        test_lifo();
        test_double_free();
        test_illegal();
        test_round_robin();
        test_reset_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
